// File: rtl/retea_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : retea_pkg                                                     |
// | Purpose  : Shared types and constants for the network sequencer: the     |
// |            controller state encoding, the layer-clear duration and an    |
// |            index-width helper.                                           |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package retea_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    ARGMAX = 3'd3,
    DONE   = 3'd4
  } stare_t;

  // Number of cycles the layers are held in reset before the first layer runs.
  localparam int CLEAR_CICLURI = 2;

  // Width of an index able to address n elements.
  function automatic int idx_latime(input int n);
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/argmax_secvential.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : argmax_secvential                                             |
// | Purpose  : Sequential arg-max over the final-layer scores, one element   |
// |            per cycle. Ties keep the lowest index.                        |
// | Ports    : clock       - system clock                                    |
// |            reset       - synchronous, active-high                        |
// |            porneste    - start a new scan (one cycle)                    |
// |            scor        - signed score array, held stable during a scan   |
// |            gata_argmax - high in the cycle the last element is examined  |
// |            index       - winning index; final value valid while          |
// |                          gata_argmax is high, then held                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module argmax_secvential
  import retea_pkg::*;
#(
  parameter int numar_clase = 10,
  parameter int latime      = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                porneste,
  input  logic signed [4*latime-1:0]          scor [0:numar_clase-1],
  output logic                                gata_argmax,
  output logic [idx_latime(numar_clase)-1:0]  index
);

  localparam int IW = idx_latime(numar_clase);
  localparam logic [IW-1:0] c_i_last = IW'(numar_clase - 1);

  logic                       r_activ;
  logic [IW-1:0]              r_i;
  logic [IW-1:0]              r_idx;
  logic signed [4*latime-1:0] r_max;

  logic signed [4*latime-1:0] w_elem;
  logic                       w_upd;

  assign w_elem = scor[r_i];
  // Element 0 always loads; later elements replace only when strictly greater,
  // so equal scores leave the earlier (lower) index in place.
  assign w_upd  = r_activ && ((r_i == '0) || (w_elem > r_max));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_activ <= 1'b0;
      r_i     <= '0;
      r_idx   <= '0;
      r_max   <= '0;
    end else if (porneste) begin
      r_activ <= 1'b1;
      r_i     <= '0;
    end else if (r_activ) begin
      if (w_upd) begin
        r_max <= w_elem;
        r_idx <= r_i;
      end
      if (r_i == c_i_last) begin
        r_activ <= 1'b0;
      end else begin
        r_i <= r_i + 1'b1;
      end
    end
  end

  assign gata_argmax = r_activ && (r_i == c_i_last);
  // Look-ahead of the index register so the caller can capture the winner
  // in the same cycle the last element is compared.
  assign index       = w_upd ? r_i : r_idx;

endmodule
`default_nettype wire

// File: rtl/network_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : network_sequencer                                             |
// | Purpose  : Inference controller for a chain of dense layers: clears the  |
// |            layers, enables them in order, then finds the winning class   |
// |            of the final layer and reports it with a one-cycle pulse.     |
// | Ports    : clock          - system clock                                 |
// |            reset          - synchronous, active-high                     |
// |            start          - one-cycle inference request                  |
// |            layer_terminat - per-layer sticky done flags                  |
// |            scor           - final-layer signed scores                    |
// |            layer_enable   - per-layer enables (cumulative)               |
// |            layer_reset    - reset to all layers                          |
// |            busy           - inference in progress                        |
// |            gata           - one-cycle completion pulse                   |
// |            predictie      - winning class index                          |
// |            eroare         - per-layer timeout flag                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module network_sequencer
  import retea_pkg::*;
#(
  parameter int numar_straturi  = 2,
  parameter int numar_clase     = 10,
  parameter int latime          = 8,
  parameter int timeout_cicluri = 4095
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [0:numar_straturi-1]         layer_terminat,
  input  logic signed [4*latime-1:0]        scor [0:numar_clase-1],
  output logic [0:numar_straturi-1]         layer_enable,
  output logic                              layer_reset,
  output logic                              busy,
  output logic                              gata,
  output logic [$clog2(numar_clase)-1:0]    predictie,
  output logic                              eroare
);

  localparam int KW = (numar_straturi > 1)  ? idx_latime(numar_straturi)  : 1;
  localparam int TW = (timeout_cicluri > 1) ? idx_latime(timeout_cicluri) : 1;
  localparam int IW = idx_latime(numar_clase);

  localparam logic [KW-1:0] c_k_last   = KW'(numar_straturi - 1);
  // The counter holds the number of completed cycles in the current layer, so
  // the timeout-th cycle is the one where it reads timeout_cicluri-1.
  localparam logic [TW-1:0] c_t_last   = TW'(timeout_cicluri - 1);
  localparam logic [1:0]    c_clr_last = 2'(CLEAR_CICLURI - 1);

  stare_t                    r_state, w_state;
  logic [KW-1:0]             r_k, w_k;
  logic [TW-1:0]             r_cnt, w_cnt;
  logic [1:0]                r_clr, w_clr;
  logic [0:numar_straturi-1] r_enable, w_enable;
  logic                      r_busy, w_busy;
  logic                      r_gata, w_gata;
  logic [IW-1:0]             r_pred, w_pred;
  logic                      r_err, w_err;

  logic                      w_porneste;
  logic                      w_gata_argmax;
  logic [IW-1:0]             w_index;

  argmax_secvential #(
    .numar_clase (numar_clase),
    .latime      (latime)
  ) u_argmax (
    .clock       (clock),
    .reset       (reset),
    .porneste    (w_porneste),
    .scor        (scor),
    .gata_argmax (w_gata_argmax),
    .index       (w_index)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_cnt    <= '0;
      r_clr    <= '0;
      r_enable <= '0;
      r_busy   <= 1'b0;
      r_gata   <= 1'b0;
      r_pred   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_k      <= w_k;
      r_cnt    <= w_cnt;
      r_clr    <= w_clr;
      r_enable <= w_enable;
      r_busy   <= w_busy;
      r_gata   <= w_gata;
      r_pred   <= w_pred;
      r_err    <= w_err;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_k        = r_k;
    w_cnt      = r_cnt;
    w_clr      = r_clr;
    w_enable   = r_enable;
    w_busy     = r_busy;
    w_gata     = 1'b0;
    w_pred     = r_pred;
    w_err      = r_err;
    w_porneste = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state = CLEAR;
          w_clr   = '0;
          w_busy  = 1'b1;
          w_err   = 1'b0;
          w_pred  = '0;
        end
      end

      CLEAR: begin
        if (r_clr == c_clr_last) begin
          w_state     = RUN;
          w_k         = '0;
          w_cnt       = '0;
          w_enable[0] = 1'b1;
        end else begin
          w_clr = r_clr + 1'b1;
        end
      end

      RUN: begin
        // Done flag is checked first so it wins over a coincident timeout.
        if (layer_terminat[r_k]) begin
          if (r_k == c_k_last) begin
            w_state    = ARGMAX;
            w_porneste = 1'b1;
          end else begin
            w_k           = r_k + 1'b1;
            w_cnt         = '0;
            w_enable[w_k] = 1'b1;
          end
        end else if (r_cnt == c_t_last) begin
          w_state  = DONE;
          w_err    = 1'b1;
          w_pred   = '0;
          w_enable = '0;
          w_busy   = 1'b0;
          w_gata   = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ARGMAX: begin
        if (w_gata_argmax) begin
          w_state  = DONE;
          w_pred   = w_index;
          w_enable = '0;
          w_busy   = 1'b0;
          w_gata   = 1'b1;
        end
      end

      DONE: begin
        w_state = IDLE;
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // Combinational so the layers are cleared in the same cycle this block is.
  assign layer_reset  = reset | (r_state == CLEAR);
  assign layer_enable = r_enable;
  assign busy         = r_busy;
  assign gata         = r_gata;
  assign predictie    = r_pred;
  assign eroare       = r_err;

endmodule
`default_nettype wire
